// File: rtl/fp12_pkg.sv
// fp12_pkg: shared fp12 field widths, exponent limits, operand struct and multiplier FSM states
package fp12_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 5;
  localparam int MANT_W = 6;
  localparam logic [EXP_W-1:0] EXP_BIAS = 5'd15;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'd30;
  localparam logic [EXP_W-1:0] EXP_SAT = 5'd31;
  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0] exp;
    logic [MANT_W-1:0] mant;
  } fp12_t;
  typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;
endpackage

// File: rtl/fp12_mant_mul.sv
// fp12_mant_mul: 7-step shift-and-add of {1,mcand} x {1,mplier}; clear zeroes acc/counter, step_en runs one step, last flags step 6
import fp12_pkg::*;
module fp12_mant_mul (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step_en,
  input  logic [MANT_W-1:0] mcand,
  input  logic [MANT_W-1:0] mplier,
  output logic [13:0]       prod,
  output logic              last
);
  logic [2:0] cnt;
  logic [MANT_W:0] mplier_ext;
  logic [13:0] addend;
  always_comb begin
    mplier_ext = {1'b1, mplier};
    addend = mplier_ext[cnt] ? ({7'd0, 1'b1, mcand} << cnt) : 14'd0;
    last = step_en && cnt == 3'd6;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      cnt <= '0;
    end else if (clear) begin
      prod <= '0;
      cnt <= '0;
    end else if (step_en) begin
      prod <= prod + addend;
      cnt <= cnt + 3'd1;
    end
  end
endmodule

// File: rtl/fp12_multiplier.sv
// fp12_multiplier: sequential fp12 multiply; start/busy/done handshake, data_input_1 x data_input_2 -> data_output (truncating, saturating, flushing)
import fp12_pkg::*;
module fp12_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] data_input_1,
  input  logic [11:0] data_input_2,
  output logic        busy,
  output logic        done,
  output logic [11:0] data_output
);
  state_t state;
  fp12_t a, b;
  logic [13:0] prod;
  logic last;
  logic sign;
  logic [6:0] e_sum;
  logic signed [6:0] e;
  logic [MANT_W-1:0] mant;
  logic [11:0] res;
  fp12_mant_mul u_mant_mul (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE && start),
    .step_en(state == MUL),
    .mcand(a.mant),
    .mplier(b.mant),
    .prod(prod),
    .last(last)
  );
  // e_sum wraps as 7-bit two's complement, so e covers -13..48 exactly
  always_comb begin
    sign = a.sign ^ b.sign;
    e_sum = {2'b00, a.exp} + {2'b00, b.exp} + {6'd0, prod[13]} - {2'b00, EXP_BIAS};
    e = signed'(e_sum);
    mant = prod[13] ? prod[12:7] : prod[11:6];
    res = (a.exp == '0 || b.exp == '0 || e < 7'sd1) ? {sign, 11'd0}
        : e > signed'({2'b00, EXP_MAX}) ? {sign, EXP_SAT, 6'd0}
        : {sign, e[4:0], mant};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      data_output <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a <= data_input_1;
            b <= data_input_2;
            busy <= 1'b1;
            state <= MUL;
          end
        end
        MUL: state <= last ? NORM : MUL;
        NORM: begin
          data_output <= res;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp12_multiplier.sv
// tb_fp12_multiplier: directed-vector bench for fp12_multiplier
module tb_fp12_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [11:0] data_input_1 = '0;
  logic [11:0] data_input_2 = '0;
  logic busy, done;
  logic [11:0] data_output;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  fp12_multiplier dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_input_1(data_input_1),
    .data_input_2(data_input_2),
    .busy(busy),
    .done(done),
    .data_output(data_output)
  );
  task automatic pulse_start(input logic [11:0] x, input logic [11:0] y);
    data_input_1 = x;
    data_input_2 = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_input_1 = 12'hFFF;
    data_input_2 = 12'hFFF;
  endtask
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (busy && done) begin
        miscompares++;
        $display("FAIL overlap: busy=%b done=%b both high at cycle %0d", busy, done, i);
      end
      if (done) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    #1;
    vectors++;
    if ({busy, done, data_output} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b out=%h, want 0 0 000", busy, done, data_output);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_op(input string name, input logic [11:0] x, input logic [11:0] y, input logic [11:0] want);
    int n;
    pulse_start(x, y);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start: busy=%b done=%b, want 1 0", name, busy, done);
    end
    wait_done(n);
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, want 8", name, n);
    end
    vectors++;
    if (data_output !== want) begin
      miscompares++;
      $display("FAIL %s result: got %h, want %h", name, data_output, want);
    end
  endtask
  task automatic test_done_clears(input logic [11:0] want);
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || data_output !== want) begin
      miscompares++;
      $display("FAIL done_clear: done=%b busy=%b out=%h, want 0 0 %h", done, busy, data_output, want);
    end
  endtask
  task automatic test_basic;
    test_op("one_x_one", 12'h3C0, 12'h3C0, 12'h3C0);
    test_done_clears(12'h3C0);
  endtask
  task automatic test_back_to_back;
    test_op("norm_hi", 12'h3E0, 12'h3E0, 12'h408);
    test_op("b2b_neg", 12'hC00, 12'h3E0, 12'hC20);
    test_done_clears(12'hC20);
  endtask
  task automatic test_special;
    test_op("saturate", 12'h780, 12'h780, 12'h7C0);
    test_op("flush", 12'h040, 12'h040, 12'h000);
    test_op("neg_zero", 12'h800, 12'h3E0, 12'h800);
    test_op("low_prod", 12'h3C0, 12'h3E0, 12'h3E0);
  endtask
  task automatic test_restart_ignored;
    int n;
    pulse_start(12'h3C0, 12'h3E0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (data_output !== 12'h3E0) begin
      miscompares++;
      $display("FAIL hold: got %h, want 3e0", data_output);
    end
    data_input_1 = 12'h780;
    data_input_2 = 12'h780;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL restart latency: got %0d cycles, want 5", n);
    end
    vectors++;
    if (data_output !== 12'h3E0) begin
      miscompares++;
      $display("FAIL restart result: got %h, want 3e0", data_output);
    end
    test_done_clears(12'h3E0);
  endtask
  task automatic test_reset_mid;
    int pulses = 0;
    pulse_start(12'hC00, 12'h3E0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, data_output} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b out=%h, want 0 0 000", busy, done, data_output);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0 || data_output !== 12'h000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: done pulses=%0d out=%h busy=%b, want 0 000 0", pulses, data_output, busy);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_special;
    test_restart_ignored;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
